// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - frame buffer and burst sequencer in front of one fully-connected layer
// Optional WAIT timeout enabled by defining FC_SEQ_TIMEOUT_EN.
module fc_layer_sequencer #(
  parameter int DIM_INPUT   = 96,
  parameter int DIM_OUTPUT  = 8,
  parameter int INPUT_W     = 16,
  parameter int OUTPUT_W    = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INPUT_W-1:0]             s_dat,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [INPUT_W-1:0]             fc_in_dat,
  output logic                           fc_in_valid,
  input  logic [DIM_OUTPUT*OUTPUT_W-1:0] fc_out_dat,
  input  logic                           fc_out_valid,
  output logic [DIM_OUTPUT*OUTPUT_W-1:0] m_dat,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           busy,
  output logic [15:0]                    frame_cnt,
  output logic                           err_timeout
);

  localparam int CNT_W = $clog2(DIM_INPUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM_INPUT - 1);
  localparam logic [CNT_W-1:0] FEED_END = CNT_W'(DIM_INPUT);

  typedef enum logic [1:0] {S_LOAD, S_FEED, S_WAIT, S_HOLD} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [INPUT_W-1:0] r_buf [DIM_INPUT];
  logic               w_accept;
  logic               w_expire;

  if (DIM_INPUT < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("fc_layer_sequencer: DIM_INPUT must be >= 2 and TIMEOUT_CYC >= 1");
  end

  // s_ready is only ever high in LOAD, so it alone qualifies the accept.
  assign w_accept = s_valid && s_ready;

  // Frame buffer carries no reset; stale contents are always overwritten before replay.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr_cnt] <= s_dat;
  end

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT_CYC - 1);
  logic [WAIT_W-1:0] r_wait_cnt;

  assign w_expire = (r_state == S_WAIT) && (r_wait_cnt == WAIT_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      err_timeout <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (w_expire && !fc_out_valid) err_timeout <= 1'b1;
    end
  end
`else
  assign w_expire    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      s_ready     <= 1'b1;
      fc_in_dat   <= '0;
      fc_in_valid <= 1'b0;
      m_dat       <= '0;
      m_valid     <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (r_wr_cnt == LAST_IDX) begin
              r_wr_cnt <= '0;
              s_ready  <= 1'b0;
              busy     <= 1'b1;
              r_state  <= S_FEED;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        // One extra FEED cycle drops fc_in_valid after the final sample.
        S_FEED: begin
          if (r_rd_cnt != FEED_END) begin
            fc_in_valid <= 1'b1;
            fc_in_dat   <= r_buf[r_rd_cnt];
            r_rd_cnt    <= r_rd_cnt + 1'b1;
          end else begin
            fc_in_valid <= 1'b0;
            r_rd_cnt    <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fc_out_valid) begin
            m_dat   <= fc_out_dat;
            m_valid <= 1'b1;
            r_state <= S_HOLD;
          end else if (w_expire) begin
            m_dat   <= '0;
            m_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - directed self-checking bench for fc_layer_sequencer
// Timeout section is exercised when FC_SEQ_TIMEOUT_EN is defined.
module tb_fc_layer_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] s_dat;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] fc_in_dat;
  logic        fc_in_valid;
  logic [63:0] fc_out_dat;
  logic        fc_out_valid;
  logic [63:0] m_dat;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_timeout;

  logic        model_valid;
  logic        spur_valid;
  logic        model_en;

  int vectors;
  int miscompares;
  logic [15:0] cap [1024];
  int n_cap;
  int n_rise;
  int bad_ready;
  int dly;
  bit armed;
  bit prev_v;

  localparam logic [63:0] LAYER_RES = 64'h1716151413121110;

  fc_layer_sequencer #(
    .DIM_INPUT(96), .DIM_OUTPUT(8), .INPUT_W(16), .OUTPUT_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .fc_in_dat(fc_in_dat), .fc_in_valid(fc_in_valid),
    .fc_out_dat(fc_out_dat), .fc_out_valid(fc_out_valid),
    .m_dat(m_dat), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fc_out_dat   = LAYER_RES;
  assign fc_out_valid = model_valid | spur_valid;

  // Layer model and burst monitor: pulse result 5 cycles after the last input sample.
  initial begin
    model_valid = 1'b0; n_cap = 0; n_rise = 0; bad_ready = 0;
    dly = 0; armed = 1'b0; prev_v = 1'b0;
  end
  always @(negedge clk) begin
    model_valid = 1'b0;
    if (fc_in_valid) begin
      if (!prev_v) n_rise++;
      if (n_cap < 1024) cap[n_cap] = fc_in_dat;
      n_cap++;
      dly = 0;
      armed = 1'b1;
    end else if (armed) begin
      dly++;
      if (dly == 5) begin
        armed = 1'b0;
        if (model_en) model_valid = 1'b1;
      end
    end
    if (busy && s_ready) bad_ready++;
    prev_v = fc_in_valid;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int first, input int n, input bit gaps);
    int g;
    int stalled;
    stalled = 0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_dat   = 16'(first + i);
      g = 0;
      while (!s_ready && g < 1000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 1000) stalled++;
      @(negedge clk);
      s_valid = 1'b0;
      if (gaps && i < n - 1) @(negedge clk);
    end
    chk("send_stall", 64'(stalled), 64'd0);
  endtask

  task automatic wait_frames(input int exp);
    for (int i = 0; i < 400; i++) begin
      if (frame_cnt == 16'(exp)) break;
      @(negedge clk);
    end
    chk("frame_done", 64'(frame_cnt), 64'(exp));
  endtask

  task automatic check_burst(input int base, input int rbase, input int first);
    chk("burst_len", 64'(n_cap - base), 64'd96);
    chk("burst_runs", 64'(n_rise - rbase), 64'd1);
    for (int i = 0; i < 96; i++)
      chk("burst_dat", 64'(cap[base + i]), 64'(16'(first + i)));
  endtask

  int b;
  int r;
  int n;
  logic [63:0] hold_dat;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; s_valid = 1'b0; s_dat = '0; m_ready = 1'b0;
    spur_valid = 1'b0; model_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fc_in_valid", 64'(fc_in_valid), 64'd0);
    chk("rst_fc_in_dat", 64'(fc_in_dat), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_dat", m_dat, 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);

    // Single frame, back-to-back upstream, downstream always ready
    m_ready = 1'b1; b = n_cap; r = n_rise;
    send(1, 96, 1'b0);
    chk("feed_s_ready", 64'(s_ready), 64'd0);
    chk("feed_busy", 64'(busy), 64'd1);
    chk("feed_lat_valid", 64'(fc_in_valid), 64'd0);
    @(negedge clk);
    chk("feed_first_valid", 64'(fc_in_valid), 64'd1);
    chk("feed_first_dat", 64'(fc_in_dat), 64'd1);
    wait_frames(1);
    check_burst(b, r, 1);
    chk("f1_m_dat", m_dat, LAYER_RES);
    chk("f1_neuron7", 64'(m_dat[63:56]), 64'h17);
    chk("f1_s_ready", 64'(s_ready), 64'd1);
    chk("f1_busy", 64'(busy), 64'd0);

    // Upstream gaps
    b = n_cap; r = n_rise;
    send(101, 96, 1'b1);
    wait_frames(2);
    check_burst(b, r, 101);
    chk("busy_s_ready", 64'(bad_ready), 64'd0);

    // Downstream backpressure
    m_ready = 1'b0; b = n_cap; r = n_rise;
    send(201, 96, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (m_valid) break;
      @(negedge clk);
    end
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    hold_dat = m_dat;
    chk("bp_m_dat", hold_dat, LAYER_RES);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(m_valid), 64'd1);
      chk("bp_hold_dat", m_dat, hold_dat);
      chk("bp_hold_s_ready", 64'(s_ready), 64'd0);
      chk("bp_hold_cnt", 64'(frame_cnt), 64'd2);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_ret_valid", 64'(m_valid), 64'd0);
    chk("bp_ret_cnt", 64'(frame_cnt), 64'd3);
    chk("bp_ret_s_ready", 64'(s_ready), 64'd1);
    check_burst(b, r, 201);

    // Spurious layer result during LOAD
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    chk("spur_m_valid", 64'(m_valid), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_s_ready", 64'(s_ready), 64'd1);
    chk("spur_cnt", 64'(frame_cnt), 64'd3);

    // Reset after 40 samples, then a full frame
    send(500, 40, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_cnt", 64'(frame_cnt), 64'd0);
    chk("mrst_s_ready", 64'(s_ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_m_dat", m_dat, 64'd0);
    b = n_cap; r = n_rise;
    send(1001, 96, 1'b0);
    wait_frames(1);
    check_burst(b, r, 1001);

`ifdef FC_SEQ_TIMEOUT_EN
    // Layer never answers: 16 WAIT cycles then a zero result
    model_en = 1'b0; m_ready = 1'b0;
    send(2001, 96, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (fc_in_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 200; i++) begin
      if (!fc_in_valid) break;
      @(negedge clk);
    end
    n = 1;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 64'(n), 64'd17);
    chk("to_m_valid", 64'(m_valid), 64'd1);
    chk("to_m_dat", m_dat, 64'd0);
    chk("to_err", 64'(err_timeout), 64'd1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("to_ret_valid", 64'(m_valid), 64'd0);
    chk("to_ret_cnt", 64'(frame_cnt), 64'd2);
    chk("to_err_sticky", 64'(err_timeout), 64'd1);
`else
    chk("no_to_err", 64'(err_timeout), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Frame-level controller in front of one fully-connected layer instance.
- Collects one input vector of DIM_INPUT samples from an upstream valid/ready stream into a local frame buffer.
- Replays the buffered vector into the layer as a gap-free burst: one sample per cycle, in_valid held high.
- Captures the layer's DIM_OUTPUT-wide result and offers it downstream on a valid/ready port. Used once per layer in the encoder/decoder chain.

Parameters:
- DIM_INPUT, 96, samples per frame; layer input dim; >=2.
- DIM_OUTPUT, 8, layer output dim.
- INPUT_W, 16, sample width; signed [9,7].
- OUTPUT_W, 8, layer result width per neuron; signed [1,7].
- TIMEOUT_CYC, 1024, maximum WAIT cycles; used only with FC_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_dat  in  INPUT_W  upstream sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  sequencer accepts a sample.
- fc_in_dat  out  INPUT_W  sample to layer; registered.
- fc_in_valid  out  1  sample valid to layer; registered.
- fc_out_dat  in  DIM_OUTPUT*OUTPUT_W  layer result; neuron k occupies bits [k*OUTPUT_W +: OUTPUT_W].
- fc_out_valid  in  1  layer result valid; 1-cycle pulse.
- m_dat  out  DIM_OUTPUT*OUTPUT_W  captured result; same packing as fc_out_dat.
- m_valid  out  1  result available downstream.
- m_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except LOAD.
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync release) forces LOAD. All counters = 0. Outputs: s_ready=1, fc_in_valid=0, fc_in_dat=0, m_valid=0, m_dat=0, busy=0, frame_cnt=0, err_timeout=0. Reset in any state aborts the frame; the partial buffer is discarded.
- States: LOAD, FEED, WAIT, HOLD.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready writes buf[wr_cnt] and increments wr_cnt.
  - The accept at wr_cnt=DIM_INPUT-1 clears wr_cnt and moves to FEED.
- FEED:
  - s_ready=0.
  - fc_in_valid=1 for exactly DIM_INPUT consecutive cycles, fc_in_dat=buf[0..DIM_INPUT-1] in order.
  - If the last sample is accepted at edge T, fc_in_valid rises after edge T+1; buf[0] is presented in cycle T+1 and buf[DIM_INPUT-1] in cycle T+DIM_INPUT.
  - Moves to WAIT with fc_in_valid=0 on the following edge. No bubbles; no stalls.
- WAIT:
  - On fc_out_valid, latch fc_out_dat into m_dat and move to HOLD with m_valid=1 the next cycle.
- HOLD:
  - m_valid=1; m_dat stable.
  - On m_valid&&m_ready: frame_cnt+1, m_valid=0, return to LOAD; s_ready=1 in the next cycle.
- fc_out_valid outside WAIT is ignored; no state change, m_dat untouched.
- s_valid outside LOAD is not accepted; upstream holds its data (s_ready=0).
- If m_ready is already high when HOLD is entered, the frame retires after a single HOLD cycle.
- Minimum frame period: DIM_INPUT (LOAD) + DIM_INPUT (FEED) + layer latency + 1 (HOLD) cycles.

Optional Feature:
- Macro: FC_SEQ_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter is cleared on WAIT entry.
  - If TIMEOUT_CYC cycles elapse with no fc_out_valid, go to HOLD with m_dat=0 and m_valid=1, and set err_timeout=1.
  - err_timeout is cleared only by rst.
  - fc_out_valid in the same cycle the count expires wins; it is a normal capture.
- Undefined: no counter; err_timeout tied 0; WAIT is unbounded.

Test Plan:
- Reset/idle: rst pulse, no stimulus -> s_ready=1, busy=0, fc_in_valid=0, m_valid=0, frame_cnt=0.
- Single frame (DIM_INPUT=96): s_dat=1..96 back-to-back; layer model pulses fc_out_valid 5 cycles after the last fc_in_valid with neuron k=0x10+k; m_ready=1.
  - fc_in_valid high exactly 96 consecutive cycles, data 1..96 in order.
  - m_dat neuron 7=0x17; frame_cnt=1.
- Upstream gaps: s_valid toggling 1,0,1,0 -> FEED still emits a gap-free 96-cycle burst; s_ready=0 during FEED/WAIT/HOLD.
- Backpressure: m_ready=0 for 20 cycles in HOLD -> m_valid held and m_dat stable; s_ready=0; frame_cnt increments only on the m_ready cycle.
- Spurious/ mid-frame reset: fc_out_valid pulse during LOAD is ignored (m_valid=0). rst after 40 samples -> next frame of 96 samples is replayed correctly, starting at buf[0].
- Timeout (macro on, TIMEOUT_CYC=16): layer model never responds -> 16 WAIT cycles, then m_valid=1, m_dat=0, err_timeout=1, which stays set after the frame retires.
